// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single-issue ALU.
// Each accepted operation executes for one cycle, then its result is held until the consumer takes it.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_o,
  output logic             rsp_c,
  output logic             rsp_s,
  output logic             rsp_p,
  output logic             rsp_z,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_any;
  logic             grant_id;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic [2:0]       lat_op;
  logic             lat_id;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             res_c;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          grant_any = 1'b1;
          // On a tie the requester not served last wins; a lone requester always wins.
          if (req0_valid && req1_valid) grant_id = ~last_grant;
          else                          grant_id = req1_valid;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit WIDTH of ext is carry for add and borrow for subtract; zero for other ops.
  always_comb begin
    ext = '0;
    case (lat_op)
      3'd0: ext = {1'b0, lat_a} + {1'b0, lat_b};
      3'd1: ext = {1'b0, lat_a} - {1'b0, lat_b};
      3'd2: ext = {1'b0, lat_a + WIDTH'(1)};
      3'd3: ext = {1'b0, lat_a - WIDTH'(1)};
      3'd4: ext = {1'b0, lat_a & lat_b};
      3'd5: ext = {1'b0, lat_a | lat_b};
      3'd6: ext = {1'b0, lat_a ^ lat_b};
      3'd7: ext = {1'b0, ~lat_a};
      default: ext = '0;
    endcase
  end

  assign res   = ext[WIDTH-1:0];
  assign res_c = ext[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_id     <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_o      <= '0;
      rsp_c      <= 1'b0;
      rsp_s      <= 1'b0;
      rsp_p      <= 1'b0;
      rsp_z      <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        last_grant <= grant_id;
        lat_id     <= grant_id;
        lat_a      <= grant_id ? req1_a  : req0_a;
        lat_b      <= grant_id ? req1_b  : req0_b;
        lat_op     <= grant_id ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        rsp_id <= lat_id;
        rsp_o  <= res;
        rsp_c  <= res_c;
        rsp_s  <= res[WIDTH-1];
        rsp_z  <= (res == '0);
        rsp_p  <= ~^res;
      end
      if (state == RESP && rsp_ready) op_count <= op_count + 16'd1;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single-requester ops plus
// sequences for round-robin, back-pressure and reset during a response.
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_o;
  logic        rsp_c, rsp_s, rsp_p, rsp_z, busy;
  logic [15:0] op_count;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_o(rsp_o),
    .rsp_c(rsp_c), .rsp_s(rsp_s), .rsp_p(rsp_p), .rsp_z(rsp_z),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [15:0] o;
    logic        c, s, p, z;
  } vec_t;

  int total = 0;
  int passed = 0;
  int both_cnt = 0;
  int unsigned exp_cnt = 0;
  vec_t vecs[11];

  always @(negedge clk) if (req0_ready && req1_ready) both_cnt++;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!(req0_ready || req1_ready) && n < 10) begin
      tick();
      n++;
    end
    check({name, ".ready_seen"}, (req0_ready || req1_ready), 1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    req0_valid = !v.id; req1_valid = v.id;
    req0_a = v.a; req0_b = v.b; req0_op = v.op;
    req1_a = v.a; req1_b = v.b; req1_op = v.op;
    rsp_ready = 1'b1;
    #1;
    wait_ready(tag);
    check({tag, ".grant"}, {req1_ready, req0_ready}, v.id ? 2'b10 : 2'b01);
    tick();
    // Scramble inputs during EXEC: the latched operands must be used.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_op = 3'd6;
    req1_a = 16'hDEAD; req1_b = 16'hBEEF; req1_op = 3'd6;
    check({tag, ".exec_valid"}, rsp_valid, 0);
    check({tag, ".exec_busy"}, busy, 1);
    tick();
    check({tag, ".valid"}, rsp_valid, 1);
    check({tag, ".id"}, rsp_id, v.id);
    check({tag, ".o"}, rsp_o, v.o);
    check({tag, ".csz p"}, {rsp_c, rsp_s, rsp_z, rsp_p}, {v.c, v.s, v.z, v.p});
    tick();
    exp_cnt++;
    check({tag, ".count"}, op_count, exp_cnt[15:0]);
    check({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    //          id    a         b         op    o         c     s     p     z
    vecs[0]  = '{1'b0, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 16'h0003, 16'h0005, 3'd1, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h00FF, 16'h1234, 3'd7, 16'hFF00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h0000, 16'h5555, 3'd3, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 16'h7FFF, 16'h0000, 3'd2, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'hF0F0, 16'h3C3C, 3'd4, 16'h3030, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 16'h1200, 16'h0034, 3'd5, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'hAAAA, 16'hAAAA, 3'd6, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 16'h1234, 16'h1111, 3'd0, 16'h2345, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h0005, 16'h0005, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 16'h8000, 16'h0001, 3'd1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    tick();
    tick();
    check("rst.ready", {req1_ready, req0_ready}, 2'b00);
    check("rst.valid", rsp_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.count", op_count, 0);
    check("rst.o", rsp_o, 0);
    check("rst.id_flags", {rsp_id, rsp_c, rsp_s, rsp_p, rsp_z}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Round-robin from reset with both requesters continuously valid.
    rst = 1'b1; tick(); rst = 1'b0;
    exp_cnt = 0;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 16'h000A; req1_b = 16'h0003; req1_op = 3'd1;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_ready($sformatf("rr%0d", k));
      check($sformatf("rr%0d.grant", k), {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
      tick();
      tick();
      check($sformatf("rr%0d.id", k), rsp_id, k % 2);
      check($sformatf("rr%0d.o", k), rsp_o, (k % 2) ? 16'h0007 : 16'h0002);
      tick();
    end
    check("rr.count", op_count, 4);

    // Back-pressure: result held for 5 cycles, no grants, count frozen.
    req1_valid = 1'b0;
    req0_a = 16'h0001; req0_b = 16'h0002; req0_op = 3'd0;
    rsp_ready = 1'b0;
    #1;
    wait_ready("bp");
    tick();
    req1_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d.valid", k), rsp_valid, 1);
      check($sformatf("bp%0d.o", k), rsp_o, 16'h0003);
      check($sformatf("bp%0d.ready", k), {req1_ready, req0_ready}, 2'b00);
      check($sformatf("bp%0d.count", k), op_count, 4);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp.count_after", op_count, 5);
    check("bp.next_grant", {req1_ready, req0_ready}, 2'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("bp.id1", rsp_id, 1);
    check("bp.o1", rsp_o, 16'h0007);
    tick();
    check("bp.count_final", op_count, 6);

    // Reset while a response is pending; req0 was last granted, yet req0 must win after reset.
    req0_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    wait_ready("rr_resp");
    tick();
    req0_valid = 1'b0;
    tick();
    check("rresp.valid_before", rsp_valid, 1);
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rresp.valid", rsp_valid, 0);
    check("rresp.busy", busy, 0);
    check("rresp.count", op_count, 0);
    check("rresp.grant", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("rresp.id", rsp_id, 0);

    check("never_both_ready", both_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
